// File: rtl/rr_arbiter8_enc.sv
// -----------------------------------------------------------------------------
// rr_arbiter8_enc
//
// Round-robin arbiter that shares one downstream resource between eight
// requesters. The winner is presented as a registered one-hot grant together
// with its 3-bit binary index, so a shared 8-to-3 select path can be steered
// directly from gnt_idx without a separate encoder stage.
//
// Fairness: the search for a winner begins at the round-robin pointer and
// walks upward modulo 8. An owner keeps the grant while it keeps requesting,
// but never for more than HOLD_MAX consecutive cycles. When a grant ends, the
// pointer moves to the slot just after the previous owner.
//
// Parameters
//   HOLD_MAX  maximum consecutive cycles one requester may own the grant
//             (1..16; 1 rotates every cycle)
//   CW        width of the hold counter (derived from HOLD_MAX, leave as is)
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset, overrides all other activity
//   req[7:0]   level-sensitive request lines, bit n = requester n
//   grant[7:0] registered one-hot grant, all zero when idle
//   gnt_idx    registered binary index of the owner, 0 when idle
//   gnt_valid  registered, high whenever grant is non-zero
// -----------------------------------------------------------------------------
module rr_arbiter8_enc #(
   parameter int HOLD_MAX = 4,
   parameter int CW       = $clog2(HOLD_MAX) + 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   output logic [7:0] grant,
   output logic [2:0] gnt_idx,
   output logic       gnt_valid
);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   // Last legal hold count; reaching it forces a release on the next edge.
   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_MAX - 1);

   // ---------------------------------------------------------------------------
   // Helper functions
   // ---------------------------------------------------------------------------

   // Round-robin pick: returns {found, index}. The loop walks offsets from the
   // farthest to the nearest, so the nearest set bit (starting at p) is the
   // last assignment and therefore the one that sticks.
   function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
      logic [3:0] res;
      logic [2:0] k;
      res = 4'b0000;
      for (int i = 7; i >= 0; i--) begin
         k = p + 3'(i);
         if (r[k]) begin
            res = {1'b1, k};
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

   // Binary index to one-hot vector; grant is always derived from the index so
   // the two outputs can never disagree.
   function automatic logic [7:0] idx_to_onehot(input logic [2:0] idx);
      return 8'b0000_0001 << idx;
   endfunction

   // ---------------------------------------------------------------------------
   // State and output registers
   // ---------------------------------------------------------------------------
   state_t        state_r;
   logic [2:0]    ptr_r;
   logic [CW-1:0] hold_cnt_r;
   logic [7:0]    grant_r;
   logic [2:0]    gnt_idx_r;
   logic          gnt_valid_r;

   // Next-state values
   state_t        state_s;
   logic [2:0]    ptr_s;
   logic [CW-1:0] hold_cnt_s;
   logic [7:0]    grant_s;
   logic [2:0]    gnt_idx_s;
   logic          gnt_valid_s;

   // Search / release helpers
   logic [2:0]    search_ptr_s;
   logic [3:0]    pick_s;
   logic          win_found_s;
   logic [2:0]    win_idx_s;
   logic          release_s;

   // Search start: in GRANT the search only matters on a release, where it must
   // use the pointer value being written on this edge (owner + 1), not the old one.
   always_comb begin
      search_ptr_s = ptr_r;
      if (state_r == GRANT) begin
         search_ptr_s = gnt_idx_r + 3'd1;
      end else begin
         search_ptr_s = ptr_r;
      end
   end

   // Combinational winner search and release detection.
   always_comb begin
      pick_s      = rr_pick(req, search_ptr_s);
      win_found_s = pick_s[3];
      win_idx_s   = pick_s[2:0];
      release_s   = 1'b0;
      if (state_r == GRANT) begin
         release_s = (req[gnt_idx_r] == 1'b0) || (hold_cnt_r == HOLD_LAST);
      end else begin
         release_s = 1'b0;
      end
   end

   // Next-state and next-output logic for the IDLE/GRANT controller.
   always_comb begin
      state_s     = state_r;
      ptr_s       = ptr_r;
      hold_cnt_s  = hold_cnt_r;
      grant_s     = grant_r;
      gnt_idx_s   = gnt_idx_r;
      gnt_valid_s = gnt_valid_r;

      case (state_r)
         IDLE: begin
            if (win_found_s) begin
               state_s     = GRANT;
               grant_s     = idx_to_onehot(win_idx_s);
               gnt_idx_s   = win_idx_s;
               gnt_valid_s = 1'b1;
               hold_cnt_s  = '0;
            end else begin
               state_s     = IDLE;
               grant_s     = 8'h00;
               gnt_idx_s   = 3'd0;
               gnt_valid_s = 1'b0;
               hold_cnt_s  = '0;
            end
         end

         GRANT: begin
            if (release_s) begin
               ptr_s = gnt_idx_r + 3'd1;
               if (win_found_s) begin
                  // Hand over on the same edge: no idle bubble between owners.
                  state_s     = GRANT;
                  grant_s     = idx_to_onehot(win_idx_s);
                  gnt_idx_s   = win_idx_s;
                  gnt_valid_s = 1'b1;
                  hold_cnt_s  = '0;
               end else begin
                  state_s     = IDLE;
                  grant_s     = 8'h00;
                  gnt_idx_s   = 3'd0;
                  gnt_valid_s = 1'b0;
                  hold_cnt_s  = '0;
               end
            end else begin
               hold_cnt_s = hold_cnt_r + CW'(1);
            end
         end

         default: begin
            // Unreachable encoding: fall back to a clean idle state.
            state_s     = IDLE;
            ptr_s       = 3'd0;
            grant_s     = 8'h00;
            gnt_idx_s   = 3'd0;
            gnt_valid_s = 1'b0;
            hold_cnt_s  = '0;
         end
      endcase
   end

   // State, pointer, counter and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         ptr_r       <= 3'd0;
         hold_cnt_r  <= '0;
         grant_r     <= 8'h00;
         gnt_idx_r   <= 3'd0;
         gnt_valid_r <= 1'b0;
      end else begin
         state_r     <= state_s;
         ptr_r       <= ptr_s;
         hold_cnt_r  <= hold_cnt_s;
         grant_r     <= grant_s;
         gnt_idx_r   <= gnt_idx_s;
         gnt_valid_r <= gnt_valid_s;
      end
   end

   assign grant     = grant_r;
   assign gnt_idx   = gnt_idx_r;
   assign gnt_valid = gnt_valid_r;

endmodule
